flash_stream_reader: RTL
========================

Name: flash_stream_reader

Overview:
- Bus-master sequencer that drives the byte-wide flash slave through its two-register protocol.
- Register protocol: write the flash byte address at offset 1, then read one byte at offset 0. Each byte needs both transactions.
- Copies a block of bytes starting at a given flash address, packs them little-endian into 32-bit words and emits them on a valid/ready stream.
- Used by the boot loader / DMA path. Sits between a control source and one master port of the system bus.

Parameters:
- SLAVE_BASE, 32'h0000_0000: bus base address of the flash slave. Bit 0 must be 0.
- TIMEOUT, 1024: maximum cycles spent in any single wait state before aborting with error. Must be ≥ 2.

Ports:
- clk_bus  in  1  bus clock; all logic on rising edge
- rst_bus  in  1  asynchronous active-high reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- src_addr  in  23  first flash byte address; latched on accepted start
- word_count  in  16  number of 32-bit words to read; latched on accepted start
- busy  out  1  high from the cycle after start until done/error pulses
- done  out  1  one-cycle pulse: all words emitted
- error  out  1  one-cycle pulse: aborted (err, rty or timeout)
- out_data  out  32  packed word
- out_index  out  16  word number of out_data (0-based)
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts when valid & ready
- m_dat_o  out  32  bus write data
- m_dat_i  in  32  bus read data; byte in [7:0]
- m_adr_o  out  32  bus address
- m_sel_o  out  4  byte select; constant 4'b1111
- m_we_o  out  1  write enable
- m_cyc_o  out  1  bus cycle
- m_stb_o  out  1  strobe
- m_stall_i  in  1  slave stall
- m_ack_i  in  1  slave ack
- m_err_i  in  1  slave error
- m_rty_i  in  1  slave retry (treated as error)

Behaviour:
- Reset (asynchronous, takes effect immediately mid-operation):
  - State IDLE. Outputs cyc, stb, we, busy, done, error, out_valid = 0. out_data, out_index, m_dat_o, m_adr_o = 0.
  - No further bus traffic after reset. The slave may still complete its own state; that response is ignored.
- States: IDLE, ADR_REQ, ADR_WAIT, DAT_REQ, DAT_WAIT, EMIT, FIN, ABORT.
- IDLE:
  - start=1 with word_count≠0: latch the command, clear the byte counter (0..3) and word counter → ADR_REQ.
  - start=1 with word_count=0: → FIN; no bus activity.
  - start while not IDLE is ignored.
- ADR_REQ: cyc=1, stb=1, we=1, adr=SLAVE_BASE|1, dat_o={9'b0, cur_addr}. Hold all bus outputs while m_stall_i=1. When stb & !stall → ADR_WAIT with stb=0 and cyc still 1.
- ADR_WAIT: on ack → DAT_REQ. On err or rty → ABORT.
- DAT_REQ: cyc=1, stb=1, we=0, adr=SLAVE_BASE. When accepted → DAT_WAIT.
- DAT_WAIT:
  - On ack: capture m_dat_i[7:0] into word bits [8*b+7:8*b], where b is the byte counter. Increment cur_addr mod 2^23 (wraps 7FFFFF→000000). Drop cyc the same edge.
  - If b=3 → EMIT; otherwise b+1 → ADR_REQ.
  - On err or rty → ABORT.
- cyc framing: cyc rises entering ADR_REQ and stays high through DAT_WAIT. It is never high in EMIT, FIN or ABORT. stb is high only in the REQ states.
- An ack or err arriving in the same cycle a request is accepted is ignored. It is valid only in the WAIT states.
- EMIT:
  - out_valid=1; out_data and out_index are stable until out_valid & out_ready.
  - On the accept edge, word counter +1. If it equals word_count → FIN; else clear b → ADR_REQ.
  - Back-pressure stalls the sequence; no prefetch.
- Timeout: a cycle counter resets on every state change and counts in ADR_REQ, ADR_WAIT, DAT_REQ, DAT_WAIT. Reaching TIMEOUT-1 → ABORT. EMIT never times out.
- FIN: done=1 for one cycle → IDLE. busy=0 the cycle done is high.
- ABORT: error=1 for one cycle → IDLE. cyc/stb=0, out_valid=0. A partial word is discarded.
- Latency with zero-wait slave (ack one cycle after acceptance): 4 cycles per byte, 16 cycles per word + 1 EMIT cycle when out_ready=1.

Test Plan:
- Basic: model slave with 1-cycle ack, flash byte n = n[7:0]; src_addr=0x000010, word_count=2 → out words 0x13121110 (index 0), 0x17161514 (index 1); done pulse one cycle after second accept; 16 total bus transactions, address writes carry 0x10..0x17.
- Wrap and stall: src_addr=0x7FFFFE, word_count=1, slave stalls each request 3 cycles → address writes 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001; bus outputs held constant during stall; single word emitted.
- Back-pressure: out_ready held 0 for 20 cycles in EMIT → out_valid/out_data/out_index stable, cyc=0, no bus traffic; accepted on first ready cycle.
- Error: slave returns err on the 3rd data read → error pulse, no out_valid for the partial word, cyc=0 next cycle, IDLE; a fresh start then succeeds.
- Timeout and zero count: TIMEOUT=16 with slave never acking → error exactly 16 cycles after entering ADR_WAIT; word_count=0 start → done next cycle, cyc never asserted.
- Async reset mid-DAT_WAIT → cyc, stb, busy, out_valid drop without a clock edge; start during busy ignored (latched command unchanged).

Source files
------------

// File: rtl/flash_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flash_stream_reader_if                                       |
// | Description : Pipelined bus master/slave signal bundle between the flash   |
// |               stream reader and the byte-wide flash slave.                 |
// | Ports       : m_dat_o/m_adr_o/m_sel_o/m_we_o/m_cyc_o/m_stb_o (master out), |
// |               m_dat_i/m_stall_i/m_ack_i/m_err_i/m_rty_i (slave response).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface flash_stream_reader_if;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic [31:0] m_adr_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_stall_i;
  logic        m_ack_i;
  logic        m_err_i;
  logic        m_rty_i;

  modport master (
    output m_dat_o, m_adr_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
    input  m_dat_i, m_stall_i, m_ack_i, m_err_i, m_rty_i
  );

  modport slave (
    input  m_dat_o, m_adr_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
    output m_dat_i, m_stall_i, m_ack_i, m_err_i, m_rty_i
  );
endinterface
`default_nettype wire

// File: rtl/flash_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flash_stream_reader                                          |
// | Description : Bus-master sequencer that reads a block of bytes from the    |
// |               two-register flash slave (address write at offset 1, data    |
// |               read at offset 0), packs them little-endian into 32-bit      |
// |               words and emits them on a valid/ready stream.                |
// | Ports       : clk_bus, rst_bus (async, active-high)                        |
// |               start, src_addr[22:0], word_count[15:0]  command             |
// |               busy, done, error                         status             |
// |               out_data[31:0], out_index[15:0], out_valid, out_ready stream |
// |               bus                                       bus master port    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module flash_stream_reader #(
  parameter logic [31:0] SLAVE_BASE = 32'h0000_0000,  // bit 0 must be 0
  parameter int unsigned TIMEOUT    = 1024            // >= 2
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic        start,
  input  logic [22:0] src_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] out_data,
  output logic [15:0] out_index,
  output logic        out_valid,
  input  logic        out_ready,
  flash_stream_reader_if.master bus
);

  localparam int unsigned       TCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADR_REQ  = 3'd1,
    S_ADR_WAIT = 3'd2,
    S_DAT_REQ  = 3'd3,
    S_DAT_WAIT = 3'd4,
    S_EMIT     = 3'd5,
    S_FIN      = 3'd6,
    S_ABORT    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [22:0]       addr_q,  addr_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       wcnt_q,  wcnt_d;
  logic [1:0]        byte_q,  byte_d;
  logic [31:0]       word_q,  word_d;
  logic [TCNT_W-1:0] tcnt_q,  tcnt_d;

  logic timed_out;
  logic bus_fail;
  logic adr_phase;
  logic dat_phase;
  logic unused_dat;

  assign timed_out  = (tcnt_q == T_LAST);
  assign bus_fail   = bus.m_err_i | bus.m_rty_i;
  assign adr_phase  = (state_q == S_ADR_REQ) || (state_q == S_ADR_WAIT);
  assign dat_phase  = (state_q == S_DAT_REQ) || (state_q == S_DAT_WAIT);
  assign unused_dat = ^bus.m_dat_i[31:8];

  // Responses are only looked at in the WAIT states, so an ack/err that
  // coincides with request acceptance is ignored by construction.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wcnt_d  = wcnt_q;
    byte_d  = byte_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count == 16'd0) begin
            state_d = S_FIN;
          end else begin
            addr_d  = src_addr;
            count_d = word_count;
            wcnt_d  = '0;
            byte_d  = '0;
            state_d = S_ADR_REQ;
          end
        end
      end
      S_ADR_REQ: begin
        if (!bus.m_stall_i) state_d = S_ADR_WAIT;
        else if (timed_out) state_d = S_ABORT;
      end
      S_ADR_WAIT: begin
        if (bus_fail)         state_d = S_ABORT;
        else if (bus.m_ack_i) state_d = S_DAT_REQ;
        else if (timed_out)   state_d = S_ABORT;
      end
      S_DAT_REQ: begin
        if (!bus.m_stall_i) state_d = S_DAT_WAIT;
        else if (timed_out) state_d = S_ABORT;
      end
      S_DAT_WAIT: begin
        if (bus_fail) begin
          state_d = S_ABORT;
        end else if (bus.m_ack_i) begin
          word_d[8*byte_q +: 8] = bus.m_dat_i[7:0];
          addr_d  = addr_q + 23'd1;            // natural 23-bit wrap
          byte_d  = byte_q + 2'd1;             // 3 wraps to 0 for the next word
          state_d = (byte_q == 2'd3) ? S_EMIT : S_ADR_REQ;
        end else if (timed_out) begin
          state_d = S_ABORT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          wcnt_d  = wcnt_q + 16'd1;
          byte_d  = '0;
          state_d = (wcnt_q + 16'd1 == count_q) ? S_FIN : S_ADR_REQ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state watchdog: restarts on every state change, only runs in bus states.
  always_comb begin
    tcnt_d = '0;
    if ((state_d == state_q) && (adr_phase || dat_phase)) tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk_bus or posedge rst_bus) begin
    if (rst_bus) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wcnt_q  <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Bus outputs decode straight from the state, so async reset clears them at once.
  assign bus.m_cyc_o = adr_phase | dat_phase;
  assign bus.m_stb_o = (state_q == S_ADR_REQ) || (state_q == S_DAT_REQ);
  assign bus.m_we_o  = adr_phase;
  assign bus.m_sel_o = 4'b1111;
  assign bus.m_adr_o = adr_phase ? (SLAVE_BASE | 32'd1) :
                       dat_phase ? SLAVE_BASE : 32'd0;
  assign bus.m_dat_o = adr_phase ? {9'b0, addr_q} : 32'd0;

  assign busy      = adr_phase | dat_phase | (state_q == S_EMIT);
  assign done      = (state_q == S_FIN);
  assign error     = (state_q == S_ABORT);
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = word_q;
  assign out_index = wcnt_q;

endmodule
`default_nettype wire
